// File: rtl/mure_block_retirer.sv
// Instruction-block retirer: folds consecutively retired uops into blocks
// (start address, halfword count, closing itype) and offers one block at a time.
package mure_pkg;
    localparam int XLEN        = 64;
    localparam int IRETIRE_LEN = 32;
    localparam int ITYPE_LEN   = 3;
    localparam int PRIV_LEN    = 2;
    localparam int CAUSE_LEN   = 5;

    typedef enum logic [ITYPE_LEN-1:0] {
        ITYPE_STD  = 3'd0,
        ITYPE_EXC  = 3'd1,
        ITYPE_INT  = 3'd2,
        ITYPE_ERET = 3'd3,
        ITYPE_NTB  = 3'd4,
        ITYPE_TB   = 3'd5,
        ITYPE_UIJ  = 3'd6,
        ITYPE_RES  = 3'd7
    } itype_e;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        itype_e              itype;
        logic                compressed;
        logic [PRIV_LEN-1:0] priv;
    } uop_entry_s;

    typedef struct packed {
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
    } exc_info_s;
endpackage

module mure_block_retirer #(
    parameter int CNT_W = mure_pkg::IRETIRE_LEN,
    parameter int XLEN  = mure_pkg::XLEN
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               uop_valid_i,
    input  mure_pkg::uop_entry_s               uop_i,
    input  mure_pkg::exc_info_s                exc_i,
    output logic                               uop_ready_o,
    input  logic                               flush_i,
    output logic                               blk_valid_o,
    input  logic                               blk_ready_i,
    output logic [XLEN-1:0]                    blk_iaddr_o,
    output logic [CNT_W-1:0]                   blk_iretire_o,
    output logic                               blk_ilastsize_o,
    output logic [mure_pkg::ITYPE_LEN-1:0]     blk_itype_o,
    output logic [mure_pkg::PRIV_LEN-1:0]      blk_priv_o,
    output logic [mure_pkg::CAUSE_LEN-1:0]     blk_cause_o,
    output logic [XLEN-1:0]                    blk_tval_o
);
    localparam int IT_W = mure_pkg::ITYPE_LEN;
    localparam int PV_W = mure_pkg::PRIV_LEN;
    localparam int CA_W = mure_pkg::CAUSE_LEN;

    // Open block
    mure_pkg::state_e   state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [XLEN-1:0]    iaddr_reg, iaddr_next;
    logic [PV_W-1:0]    priv_reg, priv_next;
    logic               lastsize_reg, lastsize_next;

    // Block slot presented to the encoder
    logic               blk_valid_reg, blk_valid_next;
    logic [XLEN-1:0]    blk_iaddr_reg, blk_iaddr_next;
    logic [CNT_W-1:0]   blk_iretire_reg, blk_iretire_next;
    logic               blk_ilastsize_reg, blk_ilastsize_next;
    logic [IT_W-1:0]    blk_itype_reg, blk_itype_next;
    logic [PV_W-1:0]    blk_priv_reg, blk_priv_next;
    logic [CA_W-1:0]    blk_cause_reg, blk_cause_next;
    logic [XLEN-1:0]    blk_tval_reg, blk_tval_next;

    logic [CNT_W:0]     size_ext;
    logic [CNT_W:0]     sum_ext;
    logic               overflow;
    mure_pkg::itype_e   itype_eff;
    logic [XLEN-1:0]    uop_pc;
    logic [XLEN-1:0]    uop_tval;
    logic               slot_free;
    logic               split;
    logic               close_forced;
    logic               accept;

    // Closing-block staging
    logic               close;
    logic [XLEN-1:0]    c_iaddr;
    logic [CNT_W-1:0]   c_cnt;
    logic               c_last;
    logic [IT_W-1:0]    c_itype;
    logic [PV_W-1:0]    c_priv;
    logic [CA_W-1:0]    c_cause;
    logic [XLEN-1:0]    c_tval;

    assign size_ext  = uop_i.compressed ? (CNT_W+1)'(1) : (CNT_W+1)'(2);
    assign sum_ext   = {1'b0, cnt_reg} + size_ext;
    // Carry out of the counter means the uop would push it past 2^CNT_W-1.
    assign overflow  = sum_ext[CNT_W];
    assign itype_eff = (uop_i.itype == mure_pkg::ITYPE_RES) ? mure_pkg::ITYPE_STD : uop_i.itype;
    assign uop_pc    = uop_i.pc[XLEN-1:0];
    assign uop_tval  = exc_i.tval[XLEN-1:0];

    assign slot_free    = ~blk_valid_reg | blk_ready_i;
    assign split        = (state_reg == mure_pkg::COUNT) & uop_valid_i &
                          ((uop_i.priv != priv_reg) | overflow);
    assign close_forced = (state_reg == mure_pkg::COUNT) & slot_free & (flush_i | split);
    assign uop_ready_o  = slot_free & ~split & ~((state_reg == mure_pkg::COUNT) & flush_i);
    assign accept       = uop_valid_i & uop_ready_o;

    always_comb begin
        state_next         = state_reg;
        cnt_next           = cnt_reg;
        iaddr_next         = iaddr_reg;
        priv_next          = priv_reg;
        lastsize_next      = lastsize_reg;

        close              = 1'b0;
        c_iaddr            = iaddr_reg;
        c_cnt              = cnt_reg;
        c_last             = lastsize_reg;
        c_itype            = mure_pkg::ITYPE_STD;
        c_priv             = priv_reg;
        c_cause            = '0;
        c_tval             = '0;

        blk_valid_next     = blk_valid_reg & ~blk_ready_i;
        blk_iaddr_next     = blk_iaddr_reg;
        blk_iretire_next   = blk_iretire_reg;
        blk_ilastsize_next = blk_ilastsize_reg;
        blk_itype_next     = blk_itype_reg;
        blk_priv_next      = blk_priv_reg;
        blk_cause_next     = blk_cause_reg;
        blk_tval_next      = blk_tval_reg;

        if (close_forced) begin
            close         = 1'b1;
            state_next    = mure_pkg::IDLE;
            cnt_next      = '0;
            lastsize_next = 1'b0;
        end else if (accept) begin
            c_itype = itype_eff;
            if (state_reg == mure_pkg::IDLE) begin
                iaddr_next    = uop_pc;
                priv_next     = uop_i.priv;
                cnt_next      = '0;
                lastsize_next = 1'b0;
                c_iaddr       = uop_pc;
                c_priv        = uop_i.priv;
                c_cnt         = '0;
                c_last        = 1'b0;
                case (itype_eff)
                    mure_pkg::ITYPE_STD: begin
                        cnt_next      = size_ext[CNT_W-1:0];
                        lastsize_next = ~uop_i.compressed;
                        state_next    = mure_pkg::COUNT;
                    end
                    mure_pkg::ITYPE_EXC, mure_pkg::ITYPE_INT: begin
                        close   = 1'b1;
                        c_cause = exc_i.cause;
                        c_tval  = uop_tval;
                    end
                    default: begin
                        close  = 1'b1;
                        c_cnt  = size_ext[CNT_W-1:0];
                        c_last = ~uop_i.compressed;
                    end
                endcase
            end else begin
                case (itype_eff)
                    mure_pkg::ITYPE_STD: begin
                        cnt_next      = sum_ext[CNT_W-1:0];
                        lastsize_next = ~uop_i.compressed;
                    end
                    // Traps close the block without counting the trapping uop.
                    mure_pkg::ITYPE_EXC, mure_pkg::ITYPE_INT: begin
                        close         = 1'b1;
                        c_cause       = exc_i.cause;
                        c_tval        = uop_tval;
                        state_next    = mure_pkg::IDLE;
                        cnt_next      = '0;
                        lastsize_next = 1'b0;
                    end
                    default: begin
                        close         = 1'b1;
                        c_cnt         = sum_ext[CNT_W-1:0];
                        c_last        = ~uop_i.compressed;
                        state_next    = mure_pkg::IDLE;
                        cnt_next      = '0;
                        lastsize_next = 1'b0;
                    end
                endcase
            end
        end

        if (close) begin
            blk_valid_next     = 1'b1;
            blk_iaddr_next     = c_iaddr;
            blk_iretire_next   = c_cnt;
            blk_ilastsize_next = c_last;
            blk_itype_next     = c_itype;
            blk_priv_next      = c_priv;
            blk_cause_next     = c_cause;
            blk_tval_next      = c_tval;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg         <= mure_pkg::IDLE;
            cnt_reg           <= '0;
            iaddr_reg         <= '0;
            priv_reg          <= '0;
            lastsize_reg      <= 1'b0;
            blk_valid_reg     <= 1'b0;
            blk_iaddr_reg     <= '0;
            blk_iretire_reg   <= '0;
            blk_ilastsize_reg <= 1'b0;
            blk_itype_reg     <= '0;
            blk_priv_reg      <= '0;
            blk_cause_reg     <= '0;
            blk_tval_reg      <= '0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            iaddr_reg         <= iaddr_next;
            priv_reg          <= priv_next;
            lastsize_reg      <= lastsize_next;
            blk_valid_reg     <= blk_valid_next;
            blk_iaddr_reg     <= blk_iaddr_next;
            blk_iretire_reg   <= blk_iretire_next;
            blk_ilastsize_reg <= blk_ilastsize_next;
            blk_itype_reg     <= blk_itype_next;
            blk_priv_reg      <= blk_priv_next;
            blk_cause_reg     <= blk_cause_next;
            blk_tval_reg      <= blk_tval_next;
        end
    end

    assign blk_valid_o     = blk_valid_reg;
    assign blk_iaddr_o     = blk_iaddr_reg;
    assign blk_iretire_o   = blk_iretire_reg;
    assign blk_ilastsize_o = blk_ilastsize_reg;
    assign blk_itype_o     = blk_itype_reg;
    assign blk_priv_o      = blk_priv_reg;
    assign blk_cause_o     = blk_cause_reg;
    assign blk_tval_o      = blk_tval_reg;

endmodule

// File: tb/tb_mure_block_retirer.sv
// Directed bench for mure_block_retirer: full-width instance plus a CNT_W=4
// instance for counter-saturation splits; closed blocks are scoreboarded.
module tb_mure_block_retirer;
    import mure_pkg::*;

    typedef struct packed {
        logic [63:0] iaddr;
        logic [31:0] iretire;
        logic        lastsize;
        logic [2:0]  itype;
        logic [1:0]  priv;
        logic [4:0]  cause;
        logic [63:0] tval;
    } blk_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uop_valid, uop_valid_s;
    uop_entry_s  uop;
    exc_info_s   exc;
    logic        flush, flush_s;
    logic        blk_ready, blk_ready_s;

    logic        uop_ready, blk_valid, blk_ilastsize;
    logic [63:0] blk_iaddr, blk_tval;
    logic [31:0] blk_iretire;
    logic [2:0]  blk_itype;
    logic [1:0]  blk_priv;
    logic [4:0]  blk_cause;

    logic        uop_ready_s, blk_valid_s, blk_ilastsize_s;
    logic [63:0] blk_iaddr_s, blk_tval_s;
    logic [3:0]  blk_iretire_s;
    logic [2:0]  blk_itype_s;
    logic [1:0]  blk_priv_s;
    logic [4:0]  blk_cause_s;

    int checks = 0;
    int fails  = 0;
    blk_t sb[$];
    blk_t sb_s[$];

    always #5 clk = ~clk;

    mure_block_retirer dut (
        .clk_i(clk), .rst_ni(rst_n), .uop_valid_i(uop_valid), .uop_i(uop), .exc_i(exc),
        .uop_ready_o(uop_ready), .flush_i(flush), .blk_valid_o(blk_valid), .blk_ready_i(blk_ready),
        .blk_iaddr_o(blk_iaddr), .blk_iretire_o(blk_iretire), .blk_ilastsize_o(blk_ilastsize),
        .blk_itype_o(blk_itype), .blk_priv_o(blk_priv), .blk_cause_o(blk_cause), .blk_tval_o(blk_tval)
    );

    mure_block_retirer #(.CNT_W(4)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .uop_valid_i(uop_valid_s), .uop_i(uop), .exc_i(exc),
        .uop_ready_o(uop_ready_s), .flush_i(flush_s), .blk_valid_o(blk_valid_s), .blk_ready_i(blk_ready_s),
        .blk_iaddr_o(blk_iaddr_s), .blk_iretire_o(blk_iretire_s), .blk_ilastsize_o(blk_ilastsize_s),
        .blk_itype_o(blk_itype_s), .blk_priv_o(blk_priv_s), .blk_cause_o(blk_cause_s), .blk_tval_o(blk_tval_s)
    );

    function automatic blk_t mk(input logic [63:0] ia, input logic [31:0] ir, input logic ls,
                                input itype_e it, input logic [1:0] pv,
                                input logic [4:0] ca, input logic [63:0] tv);
        blk_t b;
        b.iaddr = ia; b.iretire = ir; b.lastsize = ls; b.itype = it;
        b.priv = pv; b.cause = ca; b.tval = tv;
        return b;
    endfunction

    function automatic blk_t cur_blk();
        return mk(blk_iaddr, blk_iretire, blk_ilastsize, itype_e'(blk_itype), blk_priv, blk_cause, blk_tval);
    endfunction

    function automatic blk_t cur_blk_s();
        return mk(blk_iaddr_s, 32'(blk_iretire_s), blk_ilastsize_s, itype_e'(blk_itype_s),
                  blk_priv_s, blk_cause_s, blk_tval_s);
    endfunction

    // Scoreboard pop on every block handshake
    always @(negedge clk) begin
        if (rst_n === 1'b1 && blk_valid === 1'b1 && blk_ready === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
                fails++; $error("FAIL blk_unexpected: got block iaddr=%h, required none", blk_iaddr);
            end
            if (sb.size() > 0) begin
                blk_t e, g;
                e = sb.pop_front();
                g = cur_blk();
                checks++;
                assert (g === e) else begin
                    fails++;
                    $error("FAIL blk: got ia=%h ret=%0d ls=%0b it=%0d pv=%0d ca=%0d tv=%h, required ia=%h ret=%0d ls=%0b it=%0d pv=%0d ca=%0d tv=%h",
                           g.iaddr, g.iretire, g.lastsize, g.itype, g.priv, g.cause, g.tval,
                           e.iaddr, e.iretire, e.lastsize, e.itype, e.priv, e.cause, e.tval);
                end
            end
        end
        if (rst_n === 1'b1 && blk_valid_s === 1'b1 && blk_ready_s === 1'b1) begin
            checks++;
            assert (sb_s.size() > 0) else begin
                fails++; $error("FAIL blk_s_unexpected: got block iaddr=%h, required none", blk_iaddr_s);
            end
            if (sb_s.size() > 0) begin
                blk_t e, g;
                e = sb_s.pop_front();
                g = cur_blk_s();
                checks++;
                assert (g === e) else begin
                    fails++;
                    $error("FAIL blk_s: got ia=%h ret=%0d ls=%0b it=%0d pv=%0d, required ia=%h ret=%0d ls=%0b it=%0d pv=%0d",
                           g.iaddr, g.iretire, g.lastsize, g.itype, g.priv,
                           e.iaddr, e.iretire, e.lastsize, e.itype, e.priv);
                end
            end
        end
    end

    task automatic send(input bit sel, input logic [63:0] pc, input itype_e it, input logic comp,
                        input logic [1:0] pv, input logic [4:0] ca, input logic [63:0] tv);
        int n;
        uop.pc = pc; uop.itype = it; uop.compressed = comp; uop.priv = pv;
        exc.cause = ca; exc.tval = tv;
        if (sel) uop_valid_s = 1'b1; else uop_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (((sel ? uop_ready_s : uop_ready) !== 1'b1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 40) else begin
            fails++; $error("FAIL accept_timeout: waited %0d cycles for pc %h, required < 40", n, pc);
        end
        @(posedge clk); #1;
        uop_valid = 1'b0;
        uop_valid_s = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++; $error("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t snap;
        rst_n = 1'b0; uop_valid = 1'b0; uop_valid_s = 1'b0; uop = '0; exc = '0;
        flush = 1'b0; flush_s = 1'b0; blk_ready = 1'b1; blk_ready_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_valid_ready", {62'd0, blk_valid, uop_ready}, 64'd1);
        checks++;
        assert (cur_blk() === '0) else begin fails++; $error("FAIL reset_blk: got %h, required 0", cur_blk()); end
        chk("reset_s_valid_ready", {62'd0, blk_valid_s, uop_ready_s}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Mixed sizes closed by a taken branch
        send(0, 64'h8000_0000, ITYPE_STD, 1'b0, 2'd3, 5'd0, 64'd0);
        send(0, 64'h8000_0004, ITYPE_STD, 1'b1, 2'd3, 5'd0, 64'd0);
        send(0, 64'h8000_0006, ITYPE_STD, 1'b0, 2'd3, 5'd0, 64'd0);
        sb.push_back(mk(64'h8000_0000, 32'd7, 1'b1, ITYPE_TB, 2'd3, 5'd0, 64'd0));
        send(0, 64'h8000_000A, ITYPE_TB, 1'b0, 2'd3, 5'd0, 64'd0);

        // Exception closes exclusive of the trapping uop
        send(0, 64'h100, ITYPE_STD, 1'b0, 2'd3, 5'd0, 64'd0);
        sb.push_back(mk(64'h100, 32'd2, 1'b1, ITYPE_EXC, 2'd3, 5'd2, 64'hDEAD));
        send(0, 64'h104, ITYPE_EXC, 1'b0, 2'd3, 5'd2, 64'hDEAD);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: block held, uop refused, then handshake + accept together
        blk_ready = 1'b0;
        sb.push_back(mk(64'h200, 32'd2, 1'b1, ITYPE_TB, 2'd3, 5'd0, 64'd0));
        send(0, 64'h200, ITYPE_TB, 1'b0, 2'd3, 5'd0, 64'd0);
        snap = mk(64'h200, 32'd2, 1'b1, ITYPE_TB, 2'd3, 5'd0, 64'd0);
        uop.pc = 64'h300; uop.itype = ITYPE_STD; uop.compressed = 1'b0; uop.priv = 2'd3; exc = '0;
        uop_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_uop_ready", {63'd0, uop_ready}, 64'd0);
            chk("stall_blk_valid", {63'd0, blk_valid}, 64'd1);
            checks++;
            assert (cur_blk() === snap) else begin
                fails++; $error("FAIL stall_stable: got ia=%h ret=%0d, required ia=%h ret=%0d",
                                blk_iaddr, blk_iretire, snap.iaddr, snap.iretire);
            end
        end
        @(posedge clk); #1;
        blk_ready = 1'b1;
        @(negedge clk);
        chk("release_uop_ready", {63'd0, uop_ready}, 64'd1);
        @(posedge clk); #1;
        uop_valid = 1'b0;

        // Flush in COUNT closes as STD and refuses the concurrent uop
        sb.push_back(mk(64'h300, 32'd2, 1'b1, ITYPE_STD, 2'd3, 5'd0, 64'd0));
        uop.pc = 64'h400; uop.itype = ITYPE_TB; uop.compressed = 1'b1; uop.priv = 2'd3;
        uop_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_uop_ready", {63'd0, uop_ready}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        sb.push_back(mk(64'h400, 32'd1, 1'b0, ITYPE_TB, 2'd3, 5'd0, 64'd0));
        send(0, 64'h400, ITYPE_TB, 1'b1, 2'd3, 5'd0, 64'd0);

        // Privilege change splits the block
        send(0, 64'h500, ITYPE_STD, 1'b0, 2'd3, 5'd0, 64'd0);
        send(0, 64'h504, ITYPE_STD, 1'b0, 2'd3, 5'd0, 64'd0);
        sb.push_back(mk(64'h500, 32'd4, 1'b1, ITYPE_STD, 2'd3, 5'd0, 64'd0));
        uop.pc = 64'h508; uop.itype = ITYPE_STD; uop.compressed = 1'b0; uop.priv = 2'd0;
        uop_valid = 1'b1;
        @(negedge clk);
        chk("split_priv_ready_low", {63'd0, uop_ready}, 64'd0);
        @(posedge clk); #1;
        chk("split_priv_ready_high", {63'd0, uop_ready}, 64'd1);
        send(0, 64'h508, ITYPE_STD, 1'b0, 2'd0, 5'd0, 64'd0);
        sb.push_back(mk(64'h508, 32'd4, 1'b1, ITYPE_TB, 2'd0, 5'd0, 64'd0));
        send(0, 64'h50C, ITYPE_TB, 1'b0, 2'd0, 5'd0, 64'd0);

        // Reset discards an open block
        send(0, 64'h600, ITYPE_STD, 1'b0, 2'd3, 5'd0, 64'd0);
        send(0, 64'h604, ITYPE_STD, 1'b0, 2'd3, 5'd0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midreset_valid_ready", {62'd0, blk_valid, uop_ready}, 64'd1);
        sb.push_back(mk(64'h700, 32'd2, 1'b1, ITYPE_TB, 2'd3, 5'd0, 64'd0));
        send(0, 64'h700, ITYPE_TB, 1'b0, 2'd3, 5'd0, 64'd0);

        // Counter saturation on the CNT_W=4 instance
        for (int i = 0; i < 7; i++)
            send(1, 64'h1000 + 64'(4 * i), ITYPE_STD, 1'b0, 2'd1, 5'd0, 64'd0);
        sb_s.push_back(mk(64'h1000, 32'd14, 1'b1, ITYPE_STD, 2'd1, 5'd0, 64'd0));
        uop.pc = 64'h101C; uop.itype = ITYPE_STD; uop.compressed = 1'b0; uop.priv = 2'd1;
        uop_valid_s = 1'b1;
        @(negedge clk);
        chk("split_sat_ready_low", {63'd0, uop_ready_s}, 64'd0);
        @(posedge clk); #1;
        send(1, 64'h101C, ITYPE_STD, 1'b0, 2'd1, 5'd0, 64'd0);
        sb_s.push_back(mk(64'h101C, 32'd2, 1'b1, ITYPE_STD, 2'd1, 5'd0, 64'd0));
        flush_s = 1'b1;
        @(posedge clk); #1;
        flush_s = 1'b0;

        // Flush while IDLE produces nothing
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_no_block", {63'd0, blk_valid}, 64'd0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("sb_s_drained", 64'(sb_s.size()), 64'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
